// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_if
//  Description : Bundle of the fetch-unit request/response signals and the
//                memory-controller refill signals seen by the icache.
//                The slave modport is the cache side; the master modport is
//                the environment (fetch unit plus memory controller).
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        ins_ok;
    logic [31:0] ins;
    logic [31:0] mc_addr;
    logic        mc_flag;
    logic [31:0] mc_val;
    logic        mc_isok;

    modport slave (
        input  if_valid, if_pc, mc_val, mc_isok,
        output ins_ok, ins, mc_addr, mc_flag
    );

    modport master (
        output if_valid, if_pc, mc_val, mc_isok,
        input  ins_ok, ins, mc_addr, mc_flag
    );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped, read-only instruction cache with one 32-bit
//                word per line. Hits are answered combinationally; a miss
//                issues a single-word refill to the memory controller, then
//                spends one settle cycle with the request dropped before
//                returning to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   rdy,
    input  wire logic   clr,
    icache_if.slave     bus
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];
    // Word address (byte address >> 2) of the outstanding miss.
    logic [29:0]             miss_word;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_BITS-1:0]   miss_idx;
    logic [TAG_W-1:0]        miss_tag;
    logic                    hit;
    logic                    fill;
    logic                    unused_pc_bits;

    assign req_idx  = bus.if_pc[INDEX_BITS+1:2];
    assign req_tag  = bus.if_pc[31:INDEX_BITS+2];
    assign miss_idx = miss_word[INDEX_BITS-1:0];
    assign miss_tag = miss_word[29:INDEX_BITS];

    // Byte offset within the word is irrelevant to a word-granular cache.
    assign unused_pc_bits = ^bus.if_pc[1:0];

    assign hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // A refill lands only when the controller completes, the cache is
    // enabled, and no redirect is cancelling the fetch in the same cycle.
    assign fill = rdy && (state == FETCH) && bus.mc_isok && !clr;

    // Hit path is purely combinational; reset and redirect mask it.
    assign bus.ins_ok  = !rst && (state == IDLE) && bus.if_valid && !clr && hit;
    assign bus.ins     = bus.ins_ok ? data_mem[req_idx] : 32'h0;

    // Refill request is visible only while fetching; address is the latched one.
    assign bus.mc_flag = (state == FETCH);
    assign bus.mc_addr = (state == FETCH) ? {miss_word, 2'b00} : 32'h0;

    // Control FSM, valid bits and miss address; everything frozen while rdy=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            miss_word <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (bus.if_valid && !clr && !hit) begin
                        miss_word <= bus.if_pc[31:2];
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (clr) begin
                        state <= IDLE;
                    end else if (bus.mc_isok) begin
                        valid[miss_idx] <= 1'b1;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.mc_val;
        end
    end

endmodule
`default_nettype wire
